// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, bus constants and a 3-sample majority helper.
package i2c_pkg;
    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    // Raw encoding is also decoded by the master's bus-monitor debug view.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ADDR      = ST_ADDR,
        ADDR_ACK  = ST_ADDR_ACK,
        WRITE     = ST_WRITE,
        WRITE_ACK = ST_WRITE_ACK,
        READ      = ST_READ,
        READ_ACK  = ST_READ_ACK,
        WAIT_STOP = ST_WAIT_STOP
    } i2c_state_e;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
endpackage

// File: rtl/i2c_target_if.sv
// Byte-wide host handshake between the I2C target and its register wrapper.
interface i2c_target_if;
    import i2c_pkg::*;

    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_req;
    logic                  busy;
    logic                  addr_hit;
    i2c_state_e            state;

    modport slave  (output rx_data, rx_valid, tx_req, busy, addr_hit, state, input  tx_data);
    modport master (input  rx_data, rx_valid, tx_req, busy, addr_hit, state, output tx_data);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and START/STOP/edge detection.
// Optional 3-sample majority glitch filter when I2C_TARGET_FILTER_EN is defined.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, scl_d, sda_d;

    // Reset to 1 so an idle (pulled-up) bus produces no edges after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist <= '1;
            sda_hist <= '1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
        end
    end

    // Vote over the live sample and two history samples: one clk of latency.
    assign scl_s = maj3({scl_hist, scl_sync[SYNC_STAGES-1]});
    assign sda_s = maj3({sda_hist, sda_sync[SYNC_STAGES-1]});
`else
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s & sda_d & ~sda_s;
    assign stop_det  =  scl_s & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte write/read toward host, open-drain SDA, no stretching.
// Build option I2C_TARGET_FILTER_EN enables the SCL/SDA majority glitch filter.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         SCL,
    inout  wire          SDA,
    i2c_target_if.slave  host
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (SCL),
        .sda_in    (SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e            state, state_nxt;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic [6:0]            shift, shift_nxt;
    logic [6:0]            tx_shift, tx_shift_nxt;
    logic [I2C_BYTE_W-1:0] rx_data, rx_data_nxt, shift_in;
    logic                  rw, rw_nxt;
    logic                  ack_on, ack_on_nxt;
    logic                  sda_oe, sda_oe_nxt;
    logic                  busy, busy_nxt;
    logic                  rx_valid, rx_valid_nxt;
    logic                  tx_req, tx_req_nxt;
    logic                  addr_hit, addr_hit_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_shift <= '0;
            rx_data  <= '0;
            rw       <= 1'b0;
            ack_on   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            addr_hit <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            tx_shift <= tx_shift_nxt;
            rx_data  <= rx_data_nxt;
            rw       <= rw_nxt;
            ack_on   <= ack_on_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            rx_valid <= rx_valid_nxt;
            tx_req   <= tx_req_nxt;
            addr_hit <= addr_hit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        tx_shift_nxt = tx_shift;
        rx_data_nxt  = rx_data;
        rw_nxt       = rw;
        ack_on_nxt   = ack_on;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        rx_valid_nxt = 1'b0;
        tx_req_nxt   = 1'b0;
        addr_hit_nxt = 1'b0;
        shift_in     = {shift, sda_s};

        // START outranks STOP and any same-cycle SCL edge.
        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            ack_on_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            ack_on_nxt = 1'b0;
        end else begin
            unique case (state)
                ADDR: if (scl_rise) begin
                    shift_nxt   = shift_in[6:0];
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shift_in[7:1] == TARGET_ADDR) begin
                            addr_hit_nxt = 1'b1;
                            busy_nxt     = 1'b1;
                            rw_nxt       = shift_in[0];
                            tx_req_nxt   = shift_in[0];
                            ack_on_nxt   = 1'b0;
                            state_nxt    = ADDR_ACK;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                // ack_on marks the ACK clock: first fall drives, second fall ends it.
                ADDR_ACK, WRITE_ACK: if (scl_fall) begin
                    if (!ack_on) begin
                        sda_oe_nxt = 1'b1;
                        ack_on_nxt = 1'b1;
                    end else begin
                        ack_on_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        if (state == ADDR_ACK && rw) begin
                            tx_shift_nxt = host.tx_data[6:0];
                            sda_oe_nxt   = ~host.tx_data[7];
                            state_nxt    = READ;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = WRITE;
                        end
                    end
                end
                WRITE: if (scl_rise) begin
                    shift_nxt   = shift_in[6:0];
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_nxt  = shift_in;
                        rx_valid_nxt = 1'b1;
                        ack_on_nxt   = 1'b0;
                        state_nxt    = WRITE_ACK;
                    end
                end
                READ: if (scl_fall) begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        sda_oe_nxt = 1'b0;
                        ack_on_nxt = 1'b0;
                        state_nxt  = READ_ACK;
                    end else begin
                        tx_shift_nxt = {tx_shift[5:0], 1'b0};
                        sda_oe_nxt   = ~tx_shift[6];
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            busy_nxt  = 1'b0;
                            state_nxt = WAIT_STOP;
                        end else begin
                            tx_req_nxt = 1'b1;
                            ack_on_nxt = 1'b1;
                        end
                    end else if (scl_fall && ack_on) begin
                        tx_shift_nxt = host.tx_data[6:0];
                        sda_oe_nxt   = ~host.tx_data[7];
                        ack_on_nxt   = 1'b0;
                        bit_cnt_nxt  = '0;
                        state_nxt    = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    assign host.rx_data  = rx_data;
    assign host.rx_valid = rx_valid;
    assign host.tx_req   = tx_req;
    assign host.busy     = busy;
    assign host.addr_hit = addr_hit;
    assign host.state    = state;
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that answers the existing I2C master on the same SCL/SDA bus.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs it, then receives write bytes or serves read bytes through a byte-wide handshake toward the host logic (AXI-Lite register wrapper).
- Never drives SCL (no clock stretching). Drives SDA open-drain low only.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address answered.
- SYNC_STAGES, 2, flip-flop stages on the SCL/SDA input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- SCL  input  1  bus clock from master.
- SDA  inout  1  bus data; driven 0 when sda_oe, otherwise 'z'.
- rx_data  output  8  last byte written by master.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- tx_data  input  8  next byte to return on a read.
- tx_req  output  1  one-cycle pulse; host must present tx_data within 64 clk.
- busy  output  1  high from address match until STOP/START/NACK end of transfer.
- addr_hit  output  1  one-cycle pulse on address match (either direction).

Behaviour:
- Reset values: rx_data=0, rx_valid=0, tx_req=0, busy=0, addr_hit=0, sda_oe=0 (SDA='z'), state=IDLE. Synchronizer flops reset to 1.
- Edge detection uses synchronized scl_s/sda_s and their one-cycle-delayed copies.
  - START: sda_s falls while scl_s=1.
  - STOP: sda_s rises while scl_s=1.
  - Bits are sampled on the scl_s rising edge. SDA is changed on the scl_s falling edge.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- START from any state (including repeated START) goes to ADDR: bit_cnt=0, sda_oe=0, busy=0.
- STOP from any state goes to IDLE: sda_oe=0, busy=0.
- ADDR:
  - Shift in 8 bits MSB first.
  - On the 8th rising edge, if shift[7:1]==TARGET_ADDR: pulse addr_hit, set busy=1, latch rw=shift[0], go to ADDR_ACK. If rw=1, also pulse tx_req in the same cycle.
  - On mismatch go to WAIT_STOP with SDA never driven.
- ADDR_ACK:
  - Next SCL falling edge: sda_oe=1 (ACK).
  - Following falling edge: if rw=0, sda_oe=0 and go to WRITE. If rw=1, load tx_shift=tx_data, drive bit 7 (sda_oe = ~bit), go to READ.
- WRITE:
  - 8 rising edges shift in data.
  - On the 8th: rx_data<=byte, rx_valid pulse, go to WRITE_ACK.
  - WRITE_ACK: ACK driven from the next falling edge to the following falling edge, then back to WRITE.
- READ:
  - Each falling edge shifts the next bit out. After the 8th bit's falling edge, sda_oe=0 and go to READ_ACK.
  - READ_ACK samples the master bit on the rising edge:
    - 0 (ACK): pulse tx_req. At the next falling edge load tx_data and drive bit 7, then go to READ.
    - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; only START or STOP exits.
- Data transitions on SDA while SCL is high, other than START/STOP, do not exist by protocol. No protection is added beyond the START/STOP rules.
- If START and a rising edge are detected in the same clk, START wins.
- rx_valid and tx_req are never asserted in the same cycle.

Optional Feature:
- Macro I2C_TARGET_FILTER_EN.
- Defined: after the synchronizer, SCL and SDA each pass a 3-sample majority filter clocked at clk. This adds 1 clk of detection latency and rejects single-cycle glitches.
- Undefined: synchronizer output is used directly, and a single-cycle glitch on SCL is counted as an edge.

Decomposition:
- Shared package i2c_pkg: state encoding localparams (shared with the master's bus-monitor debug), I2C_ACK=1'b0, I2C_NACK=1'b1, byte width 8.
- One natural sub-module, i2c_bus_sync: synchronizer, optional filter, and rise/fall/START/STOP detection. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write to own address: master sends START, 0xA0, 0x3C, STOP.
  - Required: ACK low on both 9th clocks, addr_hit once, rx_valid once with rx_data=0x3C, busy falls at STOP.
- Address mismatch: master sends START, 0xA2, 0x55, STOP.
  - Required: SDA never driven, no rx_valid, addr_hit=0, master sees NACK.
- Two-byte read: master sends START, 0xA1; host answers tx_req with 0x96 then 0x5A; master ACKs byte 1 and NACKs byte 2, then STOP.
  - Required: bus bits 10010110 then 01011010, exactly 2 tx_req pulses, WAIT_STOP reached after the NACK.
- Repeated START: START, 0xA0, 0x01, START, 0xA1, one read byte 0xC3 with NACK, STOP.
  - Required: rx_data=0x01, read returns 0xC3, rw switches without passing through IDLE.
- Reset mid-byte: assert reset after 4 bits of a write byte.
  - Required: SDA 'z' and busy=0 the next clk. A following full write transaction is received correctly.
- With I2C_TARGET_FILTER_EN: inject 1-clk SCL low glitches during a data-high phase of 0xA0, 0x3C.
  - Required: rx_data=0x3C.
  - Without the macro: the same stimulus shows a mis-framed byte.
